// File: rtl/dkongjr_dl_pkg.sv
// rtl/dkongjr_dl_pkg.sv - shared types and defaults for the Donkey Kong Jr download controller
package dkongjr_dl_pkg;

    localparam int         DL_ADDR_W     = 19;
    localparam logic [7:0] DEF_ROM_INDEX = 8'd0;
    localparam logic [7:0] DEF_DIP_INDEX = 8'd254;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        HOLD = 3'd2,
        RUN  = 3'd3,
        ERR  = 3'd4
    } dl_state_t;

endpackage

// File: rtl/dkongjr_rst_stretch.sv
// rtl/dkongjr_rst_stretch.sv - hold timer that stretches the core reset after a download or user reset
//
// Ports:
//   clk      system clock
//   resetn   synchronous active-low reset
//   restart  reload the counter to zero (wins over en)
//   en       advance the counter by one per cycle until done
//   done     counter has reached HOLD_CYCLES-1
module dkongjr_rst_stretch #(
    parameter int HOLD_CYCLES = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic restart,
    input  logic en,
    output logic done
);

    localparam int                CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = (cnt == LAST);

endmodule

// File: rtl/dkongjr_dl_ctrl.sv
// rtl/dkongjr_dl_ctrl.sv - ioctl download/boot controller: ROM filter, DIP latch, image check, core reset
//
// Optional feature macro: DKONGJR_DL_CHECKSUM_EN (16-bit byte sum check, adds ROM_SUM and O_DL_SUM).
//
// Ports:
//   I_CLK_24576M   system clock
//   I_RESETn       synchronous active-low reset
//   I_DL_*         hps_io ioctl stream (active, write strobe, index, address, data)
//   I_USER_RST     active-high menu/button reset request
//   O_DN_*         registered ROM write bus to the core
//   O_CORE_RESETn  core reset, high only while running with no download in progress
//   O_DIP_SW       DIP byte 0
//   O_DL_OK        image valid (HOLD or RUN)
//   O_DL_ERR       last ROM download failed
//   O_DL_SUM       running byte sum (checksum build only)
//   O_BYTE_CNT     ROM bytes accepted in the current/last download
module dkongjr_dl_ctrl
    import dkongjr_dl_pkg::*;
#(
    parameter logic [7:0]           ROM_INDEX = DEF_ROM_INDEX,
    parameter logic [7:0]           DIP_INDEX = DEF_DIP_INDEX,
    parameter logic [DL_ADDR_W-1:0] ROM_BYTES = 19'h10000,
`ifdef DKONGJR_DL_CHECKSUM_EN
    parameter logic [15:0]          ROM_SUM   = 16'h0000,
`endif
    parameter int                   RST_HOLD  = 16
) (
    input  logic                 I_CLK_24576M,
    input  logic                 I_RESETn,
    input  logic                 I_DL_ACTIVE,
    input  logic                 I_DL_WR,
    input  logic [7:0]           I_DL_INDEX,
    input  logic [24:0]          I_DL_ADDR,
    input  logic [7:0]           I_DL_DATA,
    input  logic                 I_USER_RST,
    output logic [DL_ADDR_W-1:0] O_DN_ADDR,
    output logic [7:0]           O_DN_DATA,
    output logic                 O_DN_WR,
    output logic                 O_CORE_RESETn,
    output logic [7:0]           O_DIP_SW,
    output logic                 O_DL_OK,
    output logic                 O_DL_ERR,
`ifdef DKONGJR_DL_CHECKSUM_EN
    output logic [15:0]          O_DL_SUM,
`endif
    output logic [DL_ADDR_W-1:0] O_BYTE_CNT
);

    dl_state_t state;
    dl_state_t state_nxt;

    logic act_q;
    logic dl_rise;
    logic dl_fall;
    logic rom_idx;
    logic rom_rise;
    logic addr_in_range;
    logic rom_wr;
    logic wr_accept;
    logic wr_ovf;
    logic dip_wr;
    logic load_entry;
    logic ovf;
    logic sum_ok;
    logic image_ok;
    logic hold_restart;
    logic hold_en;
    logic hold_done;

    assign dl_rise       = I_DL_ACTIVE & ~act_q;
    assign dl_fall       = ~I_DL_ACTIVE & act_q;
    assign rom_idx       = (I_DL_INDEX == ROM_INDEX);
    assign rom_rise      = dl_rise & rom_idx;
    assign addr_in_range = (I_DL_ADDR < {{(25 - DL_ADDR_W){1'b0}}, ROM_BYTES});
    assign rom_wr        = I_DL_WR & rom_idx & (state == LOAD);
    assign wr_accept     = rom_wr & addr_in_range;
    assign wr_ovf        = rom_wr & ~addr_in_range;
    assign dip_wr        = I_DL_WR & (I_DL_INDEX == DIP_INDEX) & (I_DL_ADDR == 25'd0);
    assign load_entry    = (state_nxt == LOAD) & (state != LOAD);

`ifdef DKONGJR_DL_CHECKSUM_EN
    logic [15:0] sum;

    always_ff @(posedge I_CLK_24576M) begin
        if (!I_RESETn) begin
            sum <= 16'h0000;
        end else if (load_entry) begin
            sum <= 16'h0000;
        end else if (wr_accept) begin
            sum <= sum + {8'h00, I_DL_DATA};
        end
    end

    assign sum_ok   = (sum == ROM_SUM);
    assign O_DL_SUM = sum;
`else
    assign sum_ok = 1'b1;
`endif

    assign image_ok = (O_BYTE_CNT == ROM_BYTES) & ~ovf & sum_ok;

    // Restart the hold timer on every entry to HOLD, on each user reset cycle,
    // and when a side download (e.g. DIP) ends while already holding.
    assign hold_restart = (state_nxt == HOLD) & ((state != HOLD) | I_USER_RST | dl_fall);
    assign hold_en      = (state == HOLD) & ~I_DL_ACTIVE;

    dkongjr_rst_stretch #(
        .HOLD_CYCLES(RST_HOLD)
    ) u_rst_stretch (
        .clk    (I_CLK_24576M),
        .resetn (I_RESETn),
        .restart(hold_restart),
        .en     (hold_en),
        .done   (hold_done)
    );

    // State register; OK/ERR flags are registered alongside it.
    // act_q resets high so a download still active when reset releases is
    // not mistaken for a new one.
    always_ff @(posedge I_CLK_24576M) begin
        if (!I_RESETn) begin
            state    <= IDLE;
            act_q    <= 1'b1;
            O_DL_OK  <= 1'b0;
            O_DL_ERR <= 1'b0;
        end else begin
            state    <= state_nxt;
            act_q    <= I_DL_ACTIVE;
            O_DL_OK  <= (state_nxt == HOLD) | (state_nxt == RUN);
            O_DL_ERR <= (state_nxt == ERR);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rom_rise) state_nxt = LOAD;
            end
            LOAD: begin
                if (!I_DL_ACTIVE) state_nxt = image_ok ? HOLD : ERR;
            end
            HOLD: begin
                if (rom_rise)         state_nxt = LOAD;
                else if (I_DL_ACTIVE) state_nxt = HOLD;
                else if (I_USER_RST)  state_nxt = HOLD;
                else if (hold_done)   state_nxt = RUN;
            end
            RUN: begin
                if (rom_rise)         state_nxt = LOAD;
                else if (I_DL_ACTIVE) state_nxt = RUN;
                else if (dl_fall)     state_nxt = HOLD;
                else if (I_USER_RST)  state_nxt = HOLD;
            end
            ERR: begin
                if (rom_rise) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        O_CORE_RESETn = 1'b0;
        if ((state == RUN) && !I_DL_ACTIVE) O_CORE_RESETn = 1'b1;
    end

    // ROM write path, byte counter, overflow flag and DIP latch.
    always_ff @(posedge I_CLK_24576M) begin
        if (!I_RESETn) begin
            O_DN_ADDR  <= '0;
            O_DN_DATA  <= 8'h00;
            O_DN_WR    <= 1'b0;
            O_BYTE_CNT <= '0;
            O_DIP_SW   <= 8'h00;
            ovf        <= 1'b0;
        end else begin
            O_DN_WR <= wr_accept;
            if (wr_accept) begin
                O_DN_ADDR <= I_DL_ADDR[DL_ADDR_W-1:0];
                O_DN_DATA <= I_DL_DATA;
            end
            if (load_entry) begin
                O_BYTE_CNT <= '0;
                ovf        <= 1'b0;
            end else begin
                if (wr_accept && (O_BYTE_CNT != '1)) O_BYTE_CNT <= O_BYTE_CNT + 1'b1;
                if (wr_ovf) ovf <= 1'b1;
            end
            if (dip_wr) O_DIP_SW <= I_DL_DATA;
        end
    end

endmodule

// File: tb/tb_dkongjr_dl_ctrl.sv
// tb/tb_dkongjr_dl_ctrl.sv - directed self-checking bench for dkongjr_dl_ctrl
module tb_dkongjr_dl_ctrl;

    localparam int RST_HOLD = 16;

    logic        clk;
    logic        resetn;
    logic        dl_active;
    logic        dl_wr;
    logic [7:0]  dl_index;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        user_rst;
    logic [18:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        core_resetn;
    logic [7:0]  dip_sw;
    logic        dl_ok;
    logic        dl_err;
    logic [18:0] byte_cnt;
`ifdef DKONGJR_DL_CHECKSUM_EN
    logic [15:0] dl_sum;
`endif

    int checks   = 0;
    int failures = 0;

    dkongjr_dl_ctrl #(
        .ROM_INDEX(8'd0),
        .DIP_INDEX(8'd254),
        .ROM_BYTES(19'd16),
`ifdef DKONGJR_DL_CHECKSUM_EN
        .ROM_SUM  (16'h0378),
`endif
        .RST_HOLD (RST_HOLD)
    ) dut (
        .I_CLK_24576M (clk),
        .I_RESETn     (resetn),
        .I_DL_ACTIVE  (dl_active),
        .I_DL_WR      (dl_wr),
        .I_DL_INDEX   (dl_index),
        .I_DL_ADDR    (dl_addr),
        .I_DL_DATA    (dl_data),
        .I_USER_RST   (user_rst),
        .O_DN_ADDR    (dn_addr),
        .O_DN_DATA    (dn_data),
        .O_DN_WR      (dn_wr),
        .O_CORE_RESETn(core_resetn),
        .O_DIP_SW     (dip_sw),
        .O_DL_OK      (dl_ok),
        .O_DL_ERR     (dl_err),
`ifdef DKONGJR_DL_CHECKSUM_EN
        .O_DL_SUM     (dl_sum),
`endif
        .O_BYTE_CNT   (byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rom_byte(input int a);
        return 8'(a * 7 + 3);
    endfunction

    // ROM download of addr 0..nbytes-1, optional extra write at addr 16; ends
    // one tick after I_DL_ACTIVE is dropped (the edge that sees the fall).
    task automatic do_rom(input int nbytes, input bit extra);
        dl_index  = 8'd0;
        dl_active = 1'b1;
        tick();
        for (int a = 0; a < nbytes; a++) begin
            dl_wr   = 1'b1;
            dl_addr = 25'(a);
            dl_data = rom_byte(a);
            tick();
            check_eq("dn_wr_pulse", {31'd0, dn_wr}, 32'd1);
            check_eq("dn_addr", {13'd0, dn_addr}, 32'(a));
            check_eq("dn_data", {24'd0, dn_data}, {24'd0, rom_byte(a)});
        end
        if (extra) begin
            dl_wr   = 1'b1;
            dl_addr = 25'd16;
            dl_data = 8'hEE;
            tick();
            check_eq("ovf_not_fwd", {31'd0, dn_wr}, 32'd0);
        end
        dl_wr = 1'b0;
        tick();
        check_eq("dn_wr_one_cycle", {31'd0, dn_wr}, 32'd0);
        check_eq("rst_low_in_load", {31'd0, core_resetn}, 32'd0);
        dl_active = 1'b0;
        tick();
    endtask

    task automatic wait_release(output int n);
        n = 0;
        while (!core_resetn && n < 64) begin
            tick();
            n++;
        end
    endtask

    int n;

    initial begin
        resetn    = 1'b0;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_index  = 8'd0;
        dl_addr   = 25'd0;
        dl_data   = 8'd0;
        user_rst  = 1'b0;
        tick();
        tick();

        // 1: reset state, then a good 16-byte image
        check_eq("rst_core_resetn", {31'd0, core_resetn}, 32'd0);
        check_eq("rst_ok", {31'd0, dl_ok}, 32'd0);
        check_eq("rst_err", {31'd0, dl_err}, 32'd0);
        check_eq("rst_byte_cnt", {13'd0, byte_cnt}, 32'd0);
        check_eq("rst_dip", {24'd0, dip_sw}, 32'd0);
        check_eq("rst_dn_wr", {31'd0, dn_wr}, 32'd0);
        resetn = 1'b1;
        tick();
        do_rom(16, 1'b0);
        check_eq("t1_ok", {31'd0, dl_ok}, 32'd1);
        check_eq("t1_cnt", {13'd0, byte_cnt}, 32'd16);
`ifdef DKONGJR_DL_CHECKSUM_EN
        check_eq("t1_sum", {16'd0, dl_sum}, 32'h0378);
`endif
        wait_release(n);
        check_eq("t1_release_cycles", 32'(n), 32'(RST_HOLD));

        // 2: short image
        do_rom(15, 1'b0);
        check_eq("t2_err", {31'd0, dl_err}, 32'd1);
        check_eq("t2_ok", {31'd0, dl_ok}, 32'd0);
        check_eq("t2_cnt", {13'd0, byte_cnt}, 32'd15);
        repeat (20) tick();
        check_eq("t2_rst_low", {31'd0, core_resetn}, 32'd0);

        // 3: full image plus out-of-range write
        do_rom(16, 1'b1);
        check_eq("t3_err", {31'd0, dl_err}, 32'd1);
        check_eq("t3_cnt", {13'd0, byte_cnt}, 32'd16);

        // back to RUN
        do_rom(16, 1'b0);
        check_eq("t3b_err_cleared", {31'd0, dl_err}, 32'd0);
        wait_release(n);
        check_eq("t3b_release_cycles", 32'(n), 32'(RST_HOLD));

        // 4: DIP download while running
        dl_index  = 8'd254;
        dl_active = 1'b1;
        tick();
        check_eq("t4_rst_low_dip", {31'd0, core_resetn}, 32'd0);
        check_eq("t4_ok_kept", {31'd0, dl_ok}, 32'd1);
        dl_wr   = 1'b1;
        dl_addr = 25'd0;
        dl_data = 8'h5A;
        tick();
        check_eq("t4_dip_addr0", {24'd0, dip_sw}, 32'h5A);
        check_eq("t4_dip_no_rom_wr", {31'd0, dn_wr}, 32'd0);
        dl_addr = 25'd1;
        dl_data = 8'hFF;
        tick();
        dl_wr = 1'b0;
        tick();
        check_eq("t4_dip_addr1_ignored", {24'd0, dip_sw}, 32'h5A);
        dl_active = 1'b0;
        tick();
        check_eq("t4_hold_ok", {31'd0, dl_ok}, 32'd1);
        check_eq("t4_hold_rst_low", {31'd0, core_resetn}, 32'd0);
        wait_release(n);
        check_eq("t4_release_cycles", 32'(n), 32'(RST_HOLD));

        // 5: user reset pulses, second one at hold count 8
        dl_index = 8'd0;
        user_rst = 1'b1;
        tick();
        user_rst = 1'b0;
        check_eq("t5_rst_low", {31'd0, core_resetn}, 32'd0);
        repeat (8) tick();
        check_eq("t5_still_low", {31'd0, core_resetn}, 32'd0);
        user_rst = 1'b1;
        tick();
        user_rst = 1'b0;
        wait_release(n);
        check_eq("t5_release_cycles", 32'(n), 32'(RST_HOLD));
        check_eq("t5_ok", {31'd0, dl_ok}, 32'd1);

        // 6: reset mid-load, then reload
        dl_index  = 8'd0;
        dl_active = 1'b1;
        tick();
        for (int a = 0; a < 7; a++) begin
            dl_wr   = 1'b1;
            dl_addr = 25'(a);
            dl_data = rom_byte(a);
            tick();
        end
        check_eq("t6_cnt_before", {13'd0, byte_cnt}, 32'd7);
        dl_wr  = 1'b0;
        resetn = 1'b0;
        tick();
        check_eq("t6_rst_core", {31'd0, core_resetn}, 32'd0);
        check_eq("t6_rst_ok", {31'd0, dl_ok}, 32'd0);
        check_eq("t6_rst_err", {31'd0, dl_err}, 32'd0);
        check_eq("t6_rst_cnt", {13'd0, byte_cnt}, 32'd0);
        check_eq("t6_rst_dip", {24'd0, dip_sw}, 32'd0);
        check_eq("t6_rst_dn_addr", {13'd0, dn_addr}, 32'd0);
        resetn = 1'b1;
        tick();
        tick();
        dl_active = 1'b0;
        tick();
        tick();
        check_eq("t6_idle_no_reload", {31'd0, dl_ok | dl_err}, 32'd0);
        do_rom(16, 1'b0);
        check_eq("t6_ok", {31'd0, dl_ok}, 32'd1);
        wait_release(n);
        check_eq("t6_release_cycles", 32'(n), 32'(RST_HOLD));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
